// File: rtl/ikaopm_dac_rx.sv
// ikaopm_dac_rx: OPM serial audio link receiver.
// Deserializes SO slots latched by SH1/SH2 and decodes float to PCM.
module ikaopm_dac_rx #(
  parameter bit SYNC_INPUTS = 1'b0
) (
  input  logic        i_EMUCLK,
  input  logic        i_RST,
  input  logic        i_phi1_NCEN_n,
  input  logic        i_SO,
  input  logic        i_SH1,
  input  logic        i_SH2,
  input  logic        i_ERR_CLR,
  output logic [15:0] o_L,
  output logic [15:0] o_R,
  output logic        o_L_VALID,
  output logic        o_R_VALID,
  output logic        o_FRAME_ERR
);

  logic tick;
  assign tick = ~i_phi1_NCEN_n;

  logic so;
  logic sh1;
  logic sh2;

  generate
    if (SYNC_INPUTS) begin : g_sync
      logic [2:0] s1;
      logic [2:0] s2;
      always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
          s1 <= '0;
          s2 <= '0;
        end else if (tick) begin
          s1 <= {i_SO, i_SH1, i_SH2};
          s2 <= s1;
        end
      end
      assign {so, sh1, sh2} = s2;
    end else begin : g_direct
      assign {so, sh1, sh2} = {i_SO, i_SH1, i_SH2};
    end
  endgenerate

  logic [15:0] sr;
  logic [4:0]  cnt;
  logic        sh1_prev;
  logic        sh2_prev;
  logic        primed;
  logic        last_ch;
  logic [12:0] stg_w;
  logic        stg_ch;
  logic        pend;

  logic [15:0] w;
  logic        fall1;
  logic        fall2;
  logic        strobe;
  logic        both;
  logic        ch;
  logic        frame_bad;
  logic        err_set;

  assign w      = {so, sr[15:1]};
  assign fall1  = tick & sh1_prev & ~sh1;
  assign fall2  = tick & sh2_prev & ~sh2;
  assign strobe = fall1 ^ fall2;
  assign both   = fall1 & fall2;
  assign ch     = fall2;

  // a frame is 16 ticks with strict L/R alternation
  assign frame_bad = primed &
    ((cnt != 5'd15) | (ch == last_ch));
  assign err_set = both | (strobe & frame_bad);

  logic [2:0]  stg_e;
  logic [15:0] stg_m;
  logic [15:0] dec;

  assign stg_e = stg_w[12:10];
  assign stg_m = {{6{stg_w[9]}}, stg_w[9:0]};

  always_comb begin
    dec = '0;
    if (stg_e != 3'd0)
      dec = stg_m << (stg_e - 3'd1);
  end

  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      sr       <= '0;
      cnt      <= '0;
      sh1_prev <= 1'b0;
      sh2_prev <= 1'b0;
      primed   <= 1'b0;
      last_ch  <= 1'b1;
      stg_w    <= '0;
      stg_ch   <= 1'b0;
    end else if (tick) begin
      sr       <= w;
      sh1_prev <= sh1;
      sh2_prev <= sh2;
      if (fall1 | fall2)
        cnt <= '0;
      else if (cnt != 5'd31)
        cnt <= cnt + 5'd1;
      if (strobe) begin
        stg_w   <= w[15:3];
        stg_ch  <= ch;
        primed  <= 1'b1;
        last_ch <= ch;
      end
    end
  end

  // output stage runs every EMUCLK edge, one cycle behind the strobe
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      pend        <= 1'b0;
      o_L         <= '0;
      o_R         <= '0;
      o_L_VALID   <= 1'b0;
      o_R_VALID   <= 1'b0;
      o_FRAME_ERR <= 1'b0;
    end else begin
      o_L_VALID <= 1'b0;
      o_R_VALID <= 1'b0;
      if (pend) begin
        if (stg_ch) begin
          o_R       <= dec;
          o_R_VALID <= 1'b1;
        end else begin
          o_L       <= dec;
          o_L_VALID <= 1'b1;
        end
      end
      pend <= strobe;
      if (err_set)
        o_FRAME_ERR <= 1'b1;
      else if (i_ERR_CLR)
        o_FRAME_ERR <= 1'b0;
    end
  end

endmodule
